// File: rtl/rftpu_stream_ctrl_v24.sv
// Stream controller for a weight-stationary systolic array: double-buffered weight rows, activation streaming, drain.
// Performance counters and utilization are built only when RFTPU_PERF_EN is defined.
module rftpu_stream_ctrl_v24 #(
    parameter int ARRAY_DIM = 16,
    parameter int PIPE_LAT  = 2*ARRAY_DIM-1,
    parameter int CNT_W     = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [15:0]                  num_vectors,
    input  logic [7:0]                   num_tiles,
    input  logic                         weight_valid,
    output logic                         weight_ready,
    input  logic                         act_valid,
    output logic                         act_ready,
    output logic                         arr_wload,
    output logic [$clog2(ARRAY_DIM)-1:0] arr_wrow,
    output logic                         arr_wbank,
    output logic                         arr_cbank,
    output logic                         arr_act_fire,
    output logic                         result_valid,
    output logic [7:0]                   result_tile,
    output logic                         busy,
    output logic                         done,
    output logic [CNT_W-1:0]             perf_total_cycles,
    output logic [CNT_W-1:0]             perf_weight_cycles,
    output logic [CNT_W-1:0]             perf_compute_cycles,
    output logic [CNT_W-1:0]             perf_stall_cycles,
    output logic [7:0]                   utilization_pct
);
    localparam int          RW        = $clog2(ARRAY_DIM);
    localparam logic [RW:0] ROWS_LAST = (RW+1)'(ARRAY_DIM-1);
    localparam logic [RW:0] ROWS_FULL = (RW+1)'(ARRAY_DIM);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_WAIT_W = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [15:0] nvec_q, nvec_d, vec_q, vec_d;
    logic [7:0]  ntile_q, ntile_d, tile_q, tile_d;
    logic [RW:0] rows_q, rows_d;
    logic        cbank_q, cbank_d;
    logic [PIPE_LAT-1:0] vld_pipe_q;
    logic [7:0]  tile_pipe_q [PIPE_LAT];

    logic more_tiles, pf_full, w_acc, fire, row_last, last_vec;

    // rows_q counts the initial load in LOAD and the shadow-bank prefetch afterwards
    assign more_tiles   = ({1'b0, tile_q} + 9'd1) < {1'b0, ntile_q};
    assign pf_full      = (rows_q == ROWS_FULL);
    assign weight_ready = (state_q == S_LOAD) || (state_q == S_WAIT_W) ||
                          ((state_q == S_STREAM) && more_tiles && !pf_full);
    assign act_ready    = (state_q == S_STREAM);
    assign w_acc        = weight_valid && weight_ready;
    assign fire         = act_valid && act_ready;
    assign row_last     = w_acc && (rows_q == ROWS_LAST);
    assign last_vec     = (vec_q == nvec_q - 16'd1);

    assign arr_wload    = w_acc;
    assign arr_wrow     = w_acc ? rows_q[RW-1:0] : '0;
    assign arr_wbank    = w_acc && (state_q != S_LOAD) && !cbank_q;
    assign arr_cbank    = cbank_q;
    assign arr_act_fire = fire;
    assign result_valid = vld_pipe_q[PIPE_LAT-1];
    assign result_tile  = tile_pipe_q[PIPE_LAT-1];
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        nvec_d  = nvec_q;
        ntile_d = ntile_q;
        rows_d  = rows_q;
        vec_d   = vec_q;
        tile_d  = tile_q;
        cbank_d = cbank_q;
        if (w_acc) rows_d = rows_q + (RW+1)'(1);
        case (state_q)
            S_IDLE: if (start) begin
                nvec_d  = num_vectors;
                ntile_d = num_tiles;
                rows_d  = '0;
                vec_d   = '0;
                tile_d  = '0;
                cbank_d = 1'b0;
                state_d = (num_vectors == 16'd0 || num_tiles == 8'd0) ? S_DONE : S_LOAD;
            end
            S_LOAD: if (row_last) begin
                rows_d  = '0;
                state_d = S_STREAM;
            end
            S_STREAM: if (fire) begin
                if (!last_vec) begin
                    vec_d = vec_q + 16'd1;
                end else if (!more_tiles) begin
                    state_d = S_DRAIN;
                end else if (pf_full || row_last) begin
                    // shadow bank ready: swap without a bubble
                    cbank_d = !cbank_q;
                    tile_d  = tile_q + 8'd1;
                    vec_d   = '0;
                    rows_d  = '0;
                end else begin
                    vec_d   = '0;
                    state_d = S_WAIT_W;
                end
            end
            S_WAIT_W: if (row_last) begin
                cbank_d = !cbank_q;
                tile_d  = tile_q + 8'd1;
                rows_d  = '0;
                state_d = S_STREAM;
            end
            S_DRAIN: if (vld_pipe_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            nvec_q     <= '0;
            ntile_q    <= '0;
            rows_q     <= '0;
            vec_q      <= '0;
            tile_q     <= '0;
            cbank_q    <= 1'b0;
            vld_pipe_q <= '0;
            for (int i = 0; i < PIPE_LAT; i++) tile_pipe_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            nvec_q        <= nvec_d;
            ntile_q       <= ntile_d;
            rows_q        <= rows_d;
            vec_q         <= vec_d;
            tile_q        <= tile_d;
            cbank_q       <= cbank_d;
            vld_pipe_q[0] <= fire;
            tile_pipe_q[0] <= fire ? tile_q : 8'd0;
            for (int i = 1; i < PIPE_LAT; i++) begin
                vld_pipe_q[i]  <= vld_pipe_q[i-1];
                tile_pipe_q[i] <= tile_pipe_q[i-1];
            end
        end
    end

`ifdef RFTPU_PERF_EN
    logic [CNT_W-1:0] tot_q, tot_d, wt_q, wt_d, cmp_q, cmp_d, stl_q, stl_d;
    logic [7:0]       util_q, util_d;
    logic [CNT_W+6:0] prod, pct;

    always_comb begin
        tot_d  = tot_q;
        wt_d   = wt_q;
        cmp_d  = cmp_q;
        stl_d  = stl_q;
        util_d = util_q;
        if (state_q == S_IDLE && start) begin
            tot_d  = '0;
            wt_d   = '0;
            cmp_d  = '0;
            stl_d  = '0;
            util_d = '0;
        end else if (busy) begin
            tot_d = tot_q + CNT_W'(1);
            if (w_acc) wt_d = wt_q + CNT_W'(1);
            if (fire)  cmp_d = cmp_q + CNT_W'(1);
            if ((state_q == S_STREAM && !fire) || state_q == S_WAIT_W) stl_d = stl_q + CNT_W'(1);
        end
        prod = (CNT_W+7)'(cmp_d) * (CNT_W+7)'(100);
        pct  = (tot_d == '0) ? '0 : prod / (CNT_W+7)'(tot_d);
        // ratio is frozen on the cycle the job enters DONE
        if (state_d == S_DONE && state_q != S_DONE)
            util_d = (pct > (CNT_W+7)'(100)) ? 8'd100 : pct[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tot_q  <= '0;
            wt_q   <= '0;
            cmp_q  <= '0;
            stl_q  <= '0;
            util_q <= '0;
        end else begin
            tot_q  <= tot_d;
            wt_q   <= wt_d;
            cmp_q  <= cmp_d;
            stl_q  <= stl_d;
            util_q <= util_d;
        end
    end

    assign perf_total_cycles   = tot_q;
    assign perf_weight_cycles  = wt_q;
    assign perf_compute_cycles = cmp_q;
    assign perf_stall_cycles   = stl_q;
    assign utilization_pct     = util_q;
`else
    assign perf_total_cycles   = '0;
    assign perf_weight_cycles  = '0;
    assign perf_compute_cycles = '0;
    assign perf_stall_cycles   = '0;
    assign utilization_pct     = '0;
`endif

endmodule

// File: tb/tb_rftpu_stream_ctrl_v24.sv
// Directed bench for rftpu_stream_ctrl_v24 (ARRAY_DIM=16, PIPE_LAT=31); perf checks follow RFTPU_PERF_EN.
// Timing reference: rel 0 is the cycle right after the edge that samples start; done lands at last-fire rel + 33.
module tb_rftpu_stream_ctrl_v24;
    logic        clk = 1'b0;
    logic        rst, start, weight_valid, act_valid;
    logic [15:0] num_vectors;
    logic [7:0]  num_tiles;
    logic        weight_ready, act_ready, arr_wload, arr_wbank, arr_cbank, arr_act_fire;
    logic [3:0]  arr_wrow;
    logic        result_valid, busy, done;
    logic [7:0]  result_tile, utilization_pct;
    logic [31:0] perf_total_cycles, perf_weight_cycles, perf_compute_cycles, perf_stall_cycles;

    rftpu_stream_ctrl_v24 dut (
        .clk(clk), .rst(rst), .start(start), .num_vectors(num_vectors), .num_tiles(num_tiles),
        .weight_valid(weight_valid), .weight_ready(weight_ready),
        .act_valid(act_valid), .act_ready(act_ready),
        .arr_wload(arr_wload), .arr_wrow(arr_wrow), .arr_wbank(arr_wbank), .arr_cbank(arr_cbank),
        .arr_act_fire(arr_act_fire), .result_valid(result_valid), .result_tile(result_tile),
        .busy(busy), .done(done),
        .perf_total_cycles(perf_total_cycles), .perf_weight_cycles(perf_weight_cycles),
        .perf_compute_cycles(perf_compute_cycles), .perf_stall_cycles(perf_stall_cycles),
        .utilization_pct(utilization_pct)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    int cyc = 0, cyc_s = 0, t;
    int rv_cnt, fire_cnt, done_cnt;
    int rv_tile [4];
    logic cb_at [4];
    logic order_bad, wr_seen, ar_seen, ar_hi;
    logic [7:0] last_rt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        rv_cnt = 0; fire_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 4; i++) begin rv_tile[i] = 0; cb_at[i] = 1'bx; end
        order_bad = 1'b0; wr_seen = 1'b0; ar_seen = 1'b0; last_rt = 8'd0;
    endtask

    task automatic tick();
        @(posedge clk); #1; cyc++;
        if (result_valid) begin
            rv_cnt++;
            if (result_tile < 8'd4) rv_tile[result_tile[1:0]]++;
            if (result_tile < last_rt) order_bad = 1'b1;
            last_rt = result_tile;
        end
        if (arr_act_fire) begin
            if (fire_cnt % 64 == 0 && fire_cnt < 256) cb_at[fire_cnt/64] = arr_cbank;
            fire_cnt++;
        end
        if (done) done_cnt++;
        if (weight_ready) wr_seen = 1'b1;
        if (act_ready) ar_seen = 1'b1;
    endtask

    task automatic pulse(input logic [15:0] nv, input logic [7:0] nt);
        num_vectors = nv; num_tiles = nt; start = 1'b1;
        tick();
        start = 1'b0;
        cyc_s = cyc;
    endtask

    task automatic run_done(input int bound, output int rel);
        while (!done && (cyc - cyc_s) < bound) tick();
        rel = cyc - cyc_s;
    endtask

    function automatic logic [28:0] ctrl_vec();
        return {weight_ready, act_ready, arr_wload, arr_wrow, arr_wbank, arr_cbank, arr_act_fire,
                result_valid, result_tile, busy, done, utilization_pct};
    endfunction

    function automatic logic [31:0] perf_or();
        return perf_total_cycles | perf_weight_cycles | perf_compute_cycles | perf_stall_cycles;
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; num_vectors = '0; num_tiles = '0;
        weight_valid = 1'b1; act_valid = 1'b1;
        clr_mon();
        repeat (3) tick();
        chk("reset_ctrl_zero", 64'(ctrl_vec()), 64'd0);
        chk("reset_perf_zero", 64'(perf_or()), 64'd0);
        rst = 1'b0;
        tick();

        // 1 tile x 256 vectors, sources always valid
        clr_mon();
        pulse(16'd256, 8'd1);
        run_done(400, t);
        chk("s1_done_rel", 64'(t), 64'd304);
        repeat (3) tick();
        chk("s1_results", 64'(rv_cnt), 64'd256);
        chk("s1_tile0_results", 64'(rv_tile[0]), 64'd256);
        chk("s1_single_done", 64'(done_cnt), 64'd1);
`ifdef RFTPU_PERF_EN
        chk("s1_perf_total", 64'(perf_total_cycles), 64'd305);
        chk("s1_perf_weight", 64'(perf_weight_cycles), 64'd16);
        chk("s1_perf_compute", 64'(perf_compute_cycles), 64'd256);
        chk("s1_perf_stall", 64'(perf_stall_cycles), 64'd0);
        chk("s1_util", 64'(utilization_pct), 64'd84);
`else
        chk("s1_perf_tied", 64'(perf_or()), 64'd0);
        chk("s1_util_tied", 64'(utilization_pct), 64'd0);
`endif

        // 3 tiles x 64 vectors, prefetch always ready in time
        clr_mon();
        pulse(16'd64, 8'd3);
        run_done(400, t);
        chk("s2_done_rel", 64'(t), 64'd240);
        repeat (2) tick();
        chk("s2_tile0", 64'(rv_tile[0]), 64'd64);
        chk("s2_tile1", 64'(rv_tile[1]), 64'd64);
        chk("s2_tile2", 64'(rv_tile[2]), 64'd64);
        chk("s2_tile_order", 64'(order_bad), 64'd0);
        chk("s2_cbank_t0", 64'(cb_at[0]), 64'd0);
        chk("s2_cbank_t1", 64'(cb_at[1]), 64'd1);
        chk("s2_cbank_t2", 64'(cb_at[2]), 64'd0);
`ifdef RFTPU_PERF_EN
        chk("s2_perf_stall", 64'(perf_stall_cycles), 64'd0);
        chk("s2_perf_weight", 64'(perf_weight_cycles), 64'd48);
`endif

        // 2 tiles x 64, prefetch starved so tile 1 waits 40 cycles on weights
        clr_mon();
        pulse(16'd64, 8'd2);
        while (!act_ready && (cyc - cyc_s) < 100) tick();
        chk("s3_stream_rel", 64'(cyc - cyc_s), 64'd16);
        weight_valid = 1'b0;
        while (act_ready && (cyc - cyc_s) < 200) tick();
        chk("s3_wait_rel", 64'(cyc - cyc_s), 64'd80);
        chk("s3_wait_busy", 64'(busy), 64'd1);
        chk("s3_wait_wready", 64'(weight_ready), 64'd1);
        ar_hi = 1'b0;
        repeat (40) begin
            if (act_ready) ar_hi = 1'b1;
            tick();
        end
        chk("s3_act_ready_low", 64'(ar_hi), 64'd0);
        weight_valid = 1'b1;
        run_done(400, t);
        chk("s3_done_rel", 64'(t), 64'd232);
        repeat (2) tick();
        chk("s3_tile0", 64'(rv_tile[0]), 64'd64);
        chk("s3_tile1", 64'(rv_tile[1]), 64'd64);
`ifdef RFTPU_PERF_EN
        chk("s3_perf_stall", 64'(perf_stall_cycles), 64'd56);
`endif

        // zero-length jobs
        clr_mon();
        pulse(16'd0, 8'd1);
        chk("s4_done_now", 64'(done), 64'd1);
        tick();
        chk("s4_done_gone", 64'(done), 64'd0);
        chk("s4_idle", 64'(busy), 64'd0);
        chk("s4_no_ready", 64'({wr_seen, ar_seen}), 64'd0);
`ifdef RFTPU_PERF_EN
        chk("s4_util", 64'(utilization_pct), 64'd0);
        chk("s4_perf_total", 64'(perf_total_cycles), 64'd1);
`endif
        clr_mon();
        pulse(16'd5, 8'd0);
        chk("s4b_done_now", 64'(done), 64'd1);
        tick();
        chk("s4b_single_done", 64'(done_cnt), 64'd1);

        // reset in the middle of streaming
        clr_mon();
        pulse(16'd256, 8'd1);
        while ((cyc - cyc_s) < 50) tick();
        chk("s5_streaming", 64'(act_ready), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s5_ctrl_zero", 64'(ctrl_vec()), 64'd0);
        chk("s5_perf_zero", 64'(perf_or()), 64'd0);
        clr_mon();
        repeat (40) tick();
        chk("s5_no_done", 64'(done_cnt), 64'd0);
        chk("s5_no_results", 64'(rv_cnt), 64'd0);
        clr_mon();
        pulse(16'd8, 8'd1);
        run_done(200, t);
        chk("s5_fresh_done_rel", 64'(t), 64'd56);
        repeat (2) tick();
        chk("s5_fresh_results", 64'(rv_cnt), 64'd8);

        // start while busy is ignored
        clr_mon();
        pulse(16'd32, 8'd1);
        while ((cyc - cyc_s) < 30) tick();
        num_vectors = 16'd5; num_tiles = 8'd9; start = 1'b1;
        tick();
        start = 1'b0;
        run_done(400, t);
        chk("s6_done_rel", 64'(t), 64'd80);
        repeat (20) tick();
        chk("s6_single_done", 64'(done_cnt), 64'd1);
        chk("s6_results", 64'(rv_cnt), 64'd32);
`ifdef RFTPU_PERF_EN
        chk("s6_perf_compute", 64'(perf_compute_cycles), 64'd32);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
